// File: rtl/axis_frame_regen_pkg.sv
// Shared types and helpers for the AXI-Stream frame length regenerator.
package axis_frame_regen_pkg;

  typedef enum logic [1:0] {PASS, PAD, DROP} frame_state_e;

  localparam int STAT_WIDTH = 32;

  // Saturating increment for the optional statistics counters
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_frame_regen.sv
// Forces every AXI-Stream frame to exactly cfg_beats beats: pads short frames, truncates long ones.
// Optional statistics counters are enabled with macro AXIS_FRAME_REGEN_STATS_EN.
module axis_frame_regen
  import axis_frame_regen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LEN_WIDTH-1:0]  cfg_beats,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  err_short,
  output logic                  err_long,
`ifdef AXIS_FRAME_REGEN_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_short,
  output logic [STAT_WIDTH-1:0] stat_long,
`endif
  output logic                  busy
);

  frame_state_e         state, state_nxt;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
  logic [LEN_WIDTH-1:0] len, len_nxt;
  logic [LEN_WIDTH-1:0] len_cur;
  logic                 upd;
  logic                 s_hs;
  logic                 frame_start;
  logic                 last_beat;
  logic                 m_load;
  logic                 m_pad;
  logic                 err_short_d;
  logic                 err_long_d;

  assign upd  = !m_axis_tvalid || m_axis_tready;
  assign s_hs = s_axis_tvalid && s_axis_tready;

  // The first beat of a frame uses the live cfg_beats; later beats use the latched length
  assign frame_start = (state == PASS) && (cnt == '0);
  assign len_cur     = frame_start ? ((cfg_beats == '0) ? LEN_WIDTH'(1) : cfg_beats) : len;
  assign last_beat   = (cnt + LEN_WIDTH'(1)) == len_cur;

  assign busy = (state != PASS) || (cnt != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= PASS;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    case (state)
      PASS: begin
        if (s_hs) begin
          if (cnt == '0) len_nxt = len_cur;
          if (last_beat) begin
            cnt_nxt = '0;
            if (!s_axis_tlast) state_nxt = DROP;
          end else begin
            cnt_nxt = cnt + LEN_WIDTH'(1);
            if (s_axis_tlast) state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (upd) begin
          if (last_beat) begin
            cnt_nxt   = '0;
            state_nxt = PASS;
          end else begin
            cnt_nxt = cnt + LEN_WIDTH'(1);
          end
        end
      end
      DROP: begin
        if (s_hs && s_axis_tlast) state_nxt = PASS;
      end
      default: begin
        state_nxt = PASS;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: input ready, output-register load and error strobes
  always_comb begin
    s_axis_tready = 1'b0;
    m_load        = 1'b0;
    m_pad         = 1'b0;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;
    case (state)
      PASS: begin
        s_axis_tready = upd;
        m_load        = s_axis_tvalid && upd;
        err_short_d   = s_hs && s_axis_tlast && !last_beat;
        err_long_d    = s_hs && !s_axis_tlast && last_beat;
      end
      PAD: begin
        m_load = upd;
        m_pad  = 1'b1;
      end
      DROP: begin
        s_axis_tready = 1'b1;
      end
      default: ;
    endcase
  end

  // Single output register stage; holds while the sink stalls
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
    end else begin
      err_short <= err_short_d;
      err_long  <= err_long_d;
      if (upd) begin
        m_axis_tvalid <= m_load;
        if (m_load) begin
          m_axis_tdata <= m_pad ? '0 : s_axis_tdata;
          m_axis_tkeep <= m_pad ? '1 : s_axis_tkeep;
          m_axis_tuser <= m_pad ? '0 : s_axis_tuser;
          m_axis_tlast <= last_beat;
        end
      end
    end
  end

`ifdef AXIS_FRAME_REGEN_STATS_EN
  // Saturating frame / error statistics
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_frames <= '0;
      stat_short  <= '0;
      stat_long   <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) stat_frames <= sat_inc(stat_frames);
      if (err_short) stat_short <= sat_inc(stat_short);
      if (err_long)  stat_long  <= sat_inc(stat_long);
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_regen.sv
// Self-checking bench for axis_frame_regen: cycle vector table, randomised backpressure scoreboard, error/stat counts.
module tb_axis_frame_regen;

  logic        clk;
  logic        rstn;
  logic [15:0] cfg_beats;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        err_short;
  logic        err_long;
  logic        busy;
`ifdef AXIS_FRAME_REGEN_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_short;
  logic [31:0] stat_long;
`endif

  axis_frame_regen #(
    .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_beats(cfg_beats),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .err_short(err_short), .err_long(err_long),
`ifdef AXIS_FRAME_REGEN_STATS_EN
    .stat_frames(stat_frames), .stat_short(stat_short), .stat_long(stat_long),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tot++;
    n_bad++;
    $display("FAIL %s: got timeout want handshake", nm);
  endtask

  typedef struct {
    logic        rstn;
    logic [15:0] cfg;
    logic        vld;
    logic [63:0] data;
    logic        last;
    logic        mrdy;
    logic        e_srdy;
    logic        e_mvld;
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    logic        e_user;
    logic        e_last;
    logic        e_es;
    logic        e_el;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input int cfg, input logic v, input logic [63:0] d,
                              input logic l, input logic mr, input logic srdy, input logic mv,
                              input logic [63:0] ed, input logic pad, input logic el,
                              input logic es, input logic elong, input logic eb);
    vec_t x;
    x.rstn = r;   x.cfg = 16'(cfg); x.vld = v; x.data = d; x.last = l; x.mrdy = mr;
    x.e_srdy = srdy; x.e_mvld = mv; x.e_data = ed;
    x.e_keep = pad ? 8'hFF : 8'h0F;
    x.e_user = !pad;
    x.e_last = el; x.e_es = es; x.e_el = elong; x.e_busy = eb;
    return x;
  endfunction

  localparam int NV = 29;
  vec_t vt[NV];

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [63:0] rdat(input int f, input int b);
    return {1'b1, 31'(f), 32'(b)};
  endfunction

  // Drive one input beat and wait (bounded) until it is accepted
  task automatic send_beat(input int cfg, input logic [63:0] d, input logic [7:0] k,
                           input logic u, input logic l);
    logic acc;
    int g;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    cfg_beats     = 16'(cfg);
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) fail_now("send_beat");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int cfg, input int k);
    for (int b = 0; b < k; b++)
      send_beat(cfg, rdat(99, b), 8'h0F, 1'b1, b == k - 1);
  endtask

  // Pulse / frame counters for the error-count check
  logic cnt_en = 1'b0;
  int cnt_short = 0, cnt_long = 0, cnt_tlast = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if (err_short) cnt_short++;
      if (err_long)  cnt_long++;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) cnt_tlast++;
    end
  end

  int fk[40];
  int fl[40];
  logic mon_done;

  initial begin
    rstn = 1'b0; cfg_beats = 16'd4; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    s_axis_tkeep = 8'h0F; s_axis_tlast = 1'b0; s_axis_tuser = 1'b1; m_axis_tready = 1'b1;

    //          r cfg v data   l mr | srdy mv edata pad last es el busy
    vt[0]  = mk(0, 4, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0, 0, 0, 0);
    vt[1]  = mk(1, 4, 1, 64'h1,  0, 1,  1, 1, 64'h1,  0, 0, 0, 0, 1);
    vt[2]  = mk(1, 4, 1, 64'h2,  0, 1,  1, 1, 64'h2,  0, 0, 0, 0, 1);
    vt[3]  = mk(1, 4, 1, 64'h3,  0, 1,  1, 1, 64'h3,  0, 0, 0, 0, 1);
    vt[4]  = mk(1, 4, 1, 64'h4,  1, 1,  1, 1, 64'h4,  0, 1, 0, 0, 0);
    vt[5]  = mk(1, 4, 1, 64'hA,  0, 1,  1, 1, 64'hA,  0, 0, 0, 0, 1);
    vt[6]  = mk(1, 4, 1, 64'hB,  1, 1,  1, 1, 64'hB,  0, 0, 1, 0, 1);
    vt[7]  = mk(1, 3, 1, 64'hC,  0, 1,  0, 1, 64'h0,  1, 0, 0, 0, 1);
    vt[8]  = mk(1, 3, 1, 64'hC,  0, 1,  0, 1, 64'h0,  1, 1, 0, 0, 0);
    vt[9]  = mk(1, 3, 1, 64'hC,  0, 1,  1, 1, 64'hC,  0, 0, 0, 0, 1);
    vt[10] = mk(1, 3, 1, 64'hD,  0, 1,  1, 1, 64'hD,  0, 0, 0, 0, 1);
    vt[11] = mk(1, 3, 1, 64'hE,  0, 1,  1, 1, 64'hE,  0, 1, 0, 1, 1);
    vt[12] = mk(1, 3, 1, 64'hF,  0, 1,  1, 0, 64'h0,  0, 0, 0, 0, 1);
    vt[13] = mk(1, 3, 1, 64'h10, 1, 1,  1, 0, 64'h0,  0, 0, 0, 0, 0);
    vt[14] = mk(1, 3, 1, 64'h11, 0, 1,  1, 1, 64'h11, 0, 0, 0, 0, 1);
    vt[15] = mk(1, 3, 1, 64'h12, 0, 1,  1, 1, 64'h12, 0, 0, 0, 0, 1);
    vt[16] = mk(1, 3, 1, 64'h13, 1, 1,  1, 1, 64'h13, 0, 1, 0, 0, 0);
    vt[17] = mk(1, 0, 1, 64'h21, 1, 1,  1, 1, 64'h21, 0, 1, 0, 0, 0);
    vt[18] = mk(1, 0, 1, 64'h22, 1, 1,  1, 1, 64'h22, 0, 1, 0, 0, 0);
    vt[19] = mk(1, 2, 1, 64'h31, 0, 1,  1, 1, 64'h31, 0, 0, 0, 0, 1);
    vt[20] = mk(1, 5, 1, 64'h32, 1, 1,  1, 1, 64'h32, 0, 1, 0, 0, 0);
    vt[21] = mk(1, 2, 1, 64'h41, 0, 0,  0, 1, 64'h32, 0, 1, 0, 0, 0);
    vt[22] = mk(1, 2, 1, 64'h41, 0, 1,  1, 1, 64'h41, 0, 0, 0, 0, 1);
    vt[23] = mk(1, 2, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0, 0, 0, 1);
    vt[24] = mk(1, 2, 1, 64'h42, 1, 1,  1, 1, 64'h42, 0, 1, 0, 0, 0);
    vt[25] = mk(1, 4, 1, 64'h51, 0, 1,  1, 1, 64'h51, 0, 0, 0, 0, 1);
    vt[26] = mk(0, 4, 1, 64'h52, 0, 1,  1, 0, 64'h0,  0, 0, 0, 0, 0);
    vt[27] = mk(1, 2, 1, 64'h61, 0, 1,  1, 1, 64'h61, 0, 0, 0, 0, 1);
    vt[28] = mk(1, 2, 1, 64'h62, 1, 1,  1, 1, 64'h62, 0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rstn          = vt[i].rstn;
      cfg_beats     = vt[i].cfg;
      s_axis_tvalid = vt[i].vld;
      s_axis_tdata  = vt[i].data;
      s_axis_tlast  = vt[i].last;
      m_axis_tready = vt[i].mrdy;
      #1;
      chk($sformatf("v%0d s_tready", i), 64'(s_axis_tready), 64'(vt[i].e_srdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d m_tvalid", i), 64'(m_axis_tvalid), 64'(vt[i].e_mvld));
      if (vt[i].e_mvld) begin
        chk($sformatf("v%0d m_tdata", i), m_axis_tdata, vt[i].e_data);
        chk($sformatf("v%0d m_tkeep", i), 64'(m_axis_tkeep), 64'(vt[i].e_keep));
        chk($sformatf("v%0d m_tuser", i), 64'(m_axis_tuser), 64'(vt[i].e_user));
        chk($sformatf("v%0d m_tlast", i), 64'(m_axis_tlast), 64'(vt[i].e_last));
      end
      chk($sformatf("v%0d err_short", i), 64'(err_short), 64'(vt[i].e_es));
      chk($sformatf("v%0d err_long", i), 64'(err_long), 64'(vt[i].e_el));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
    end

    // Drain the output register before the randomised phase
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drain m_tvalid", 64'(m_axis_tvalid), 64'h0);

    for (int f = 0; f < 40; f++) begin
      int ln;
      fk[f] = int'($urandom_range(1, 6));
      fl[f] = int'($urandom_range(0, 5));
      ln = (fl[f] == 0) ? 1 : fl[f];
      for (int i = 0; i < ln; i++) begin
        beat_t bt;
        if (i < fk[f]) begin
          bt.data = rdat(f, i); bt.keep = 8'(f * 7 + i + 1); bt.user = 1'(i);
        end else begin
          bt.data = '0; bt.keep = 8'hFF; bt.user = 1'b0;
        end
        bt.last = (i == ln - 1);
        exp_q.push_back(bt);
      end
    end

    mon_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++)
          for (int b = 0; b < fk[f]; b++)
            send_beat((b == 0) ? fl[f] : int'($urandom_range(0, 9)), rdat(f, b),
                      8'(f * 7 + b + 1), 1'(b), b == fk[f] - 1);
      end
      begin
        while (!mon_done) begin
          m_axis_tready = ($urandom_range(0, 99) < 30);
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
      begin
        int cyc;
        logic held;
        logic [63:0] hd;
        cyc  = 0;
        held = 1'b0;
        hd   = '0;
        while (exp_q.size() > 0 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (held) begin
            chk("stall m_tvalid", 64'(m_axis_tvalid), 64'h1);
            chk("stall m_tdata", m_axis_tdata, hd);
            held = 1'b0;
          end
          if (m_axis_tvalid && m_axis_tready) begin
            beat_t e;
            e = exp_q.pop_front();
            chk("rand m_tdata", m_axis_tdata, e.data);
            chk("rand m_tkeep", 64'(m_axis_tkeep), 64'(e.keep));
            chk("rand m_tuser", 64'(m_axis_tuser), 64'(e.user));
            chk("rand m_tlast", 64'(m_axis_tlast), 64'(e.last));
          end else if (m_axis_tvalid) begin
            held = 1'b1;
            hd   = m_axis_tdata;
          end
        end
        if (exp_q.size() != 0) fail_now("rand drain");
        mon_done = 1'b1;
      end
    join

    repeat (4) @(posedge clk);
    #1;
    chk("rand no extra beat", 64'(m_axis_tvalid), 64'h0);
    chk("rand idle busy", 64'(busy), 64'h0);

    // Error pulse and frame counts: 10 normal, 2 short, 1 long
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    cnt_en = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(2, 2);
    send_frame(4, 1);
    send_frame(4, 1);
    send_frame(2, 3);
    repeat (8) @(posedge clk);
    #1;
    cnt_en = 1'b0;
    chk("cnt tlast", 64'(cnt_tlast), 64'd13);
    chk("cnt err_short", 64'(cnt_short), 64'd2);
    chk("cnt err_long", 64'(cnt_long), 64'd1);
`ifdef AXIS_FRAME_REGEN_STATS_EN
    chk("stat_frames", 64'(stat_frames), 64'd13);
    chk("stat_short", 64'(stat_short), 64'd2);
    chk("stat_long", 64'(stat_long), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
